// File: rtl/matmul_pkg.sv
// Shared types and constants for the parametrised matrix-multiply control path.
// The read tag travels alongside each A/B read so the accumulator knows when products arrive.
package matmul_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StDrain,
        StLatch,
        StWrite,
        StDone
    } state_e;

    localparam int unsigned DefAddrW = 4;

    localparam int unsigned TagW     = 3;
    localparam int unsigned TagValid = 2;
    localparam int unsigned TagFirst = 1;
    localparam int unsigned TagLast  = 0;

endpackage

// File: rtl/matmul_rd_tag_pipe.sv
// Tag delay line matching the A/B memory read latency; the tail tag marks a valid product.
// Frozen by the same enable that freezes the memory read pipes.
module matmul_rd_tag_pipe
    import matmul_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic [TagW-1:0] tag_in,
    output logic [TagW-1:0] tag_out
);

    logic [RD_LAT-1:0][TagW-1:0] pipe_q, pipe_d;

    always_comb begin
        pipe_d = pipe_q;
        if (en) begin
            pipe_d[0] = tag_in;
            for (int s = 1; s < RD_LAT; s++) begin
                pipe_d[s] = pipe_q[s-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign tag_out = pipe_q[RD_LAT-1];

endmodule

// File: rtl/matmul_ctrl_param.sv
// Control path for C[M x P] = A[M x K] * B[K x P]: issues reads, steers the accumulator,
// latches and writes each result element, with a start/busy/done handshake and global stall.
module matmul_ctrl_param
    import matmul_pkg::*;
#(
    parameter int unsigned DIM_M  = 10,
    parameter int unsigned DIM_K  = 10,
    parameter int unsigned DIM_P  = 10,
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stall,
    output logic              busy,
    output logic              done,
    output logic              rd_en_a,
    output logic [ADDR_W-1:0] row_addr_a,
    output logic [ADDR_W-1:0] col_addr_a,
    output logic              rd_en_b,
    output logic [ADDR_W-1:0] row_addr_b,
    output logic [ADDR_W-1:0] col_addr_b,
    output logic              acc_en,
    output logic              acc_first,
    output logic              res_en,
    output logic              wr_en_c,
    output logic [ADDR_W-1:0] row_addr_c,
    output logic [ADDR_W-1:0] col_addr_c
);

    localparam int unsigned IW = (DIM_M > 1) ? $clog2(DIM_M) : 1;
    localparam int unsigned KW = (DIM_K > 1) ? $clog2(DIM_K) : 1;
    localparam int unsigned JW = (DIM_P > 1) ? $clog2(DIM_P) : 1;

    localparam logic [IW-1:0] ILast = IW'(DIM_M - 1);
    localparam logic [KW-1:0] KLast = KW'(DIM_K - 1);
    localparam logic [JW-1:0] JLast = JW'(DIM_P - 1);

    if (DIM_M > 2**ADDR_W || DIM_K > 2**ADDR_W || DIM_P > 2**ADDR_W) begin : g_bad_addr_w
        $error("matmul_ctrl_param: a dimension exceeds the ADDR_W address range");
    end
    if (DIM_M < 1 || DIM_K < 1 || DIM_P < 1 || RD_LAT < 1) begin : g_bad_dim
        $error("matmul_ctrl_param: dimensions and RD_LAT must be at least 1");
    end

    state_e          state_q, state_d;
    logic [IW-1:0]   i_q, i_d;
    logic [KW-1:0]   k_q, k_d;
    logic [JW-1:0]   j_q, j_d;
    logic [TagW-1:0] tag_in, tag_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        if (!stall) begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d = StIssue;
                        i_d     = '0;
                        j_d     = '0;
                        k_d     = '0;
                    end
                end
                StIssue: begin
                    if (k_q == KLast) begin
                        k_d     = '0;
                        state_d = StDrain;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
                // Leave once the final product of this dot product has reached the accumulator.
                StDrain: begin
                    if (tag_out[TagValid] && tag_out[TagLast]) begin
                        state_d = StLatch;
                    end
                end
                StLatch: state_d = StWrite;
                StWrite: begin
                    if (i_q == ILast && j_q == JLast) begin
                        state_d = StDone;
                    end else begin
                        state_d = StIssue;
                        if (j_q == JLast) begin
                            j_d = '0;
                            i_d = i_q + 1'b1;
                        end else begin
                            j_d = j_q + 1'b1;
                        end
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        tag_in = '0;
        if (state_q == StIssue) begin
            tag_in[TagValid] = 1'b1;
            tag_in[TagFirst] = (k_q == '0);
            tag_in[TagLast]  = (k_q == KLast);
        end
    end

    matmul_rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_tag_pipe (
        .clk     (clk),
        .reset   (reset),
        .en      (!stall),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    always_comb begin
        busy       = (state_q != StIdle);
        rd_en_a    = (state_q == StIssue) && !stall;
        rd_en_b    = (state_q == StIssue) && !stall;
        acc_en     = tag_out[TagValid] && !stall;
        acc_first  = tag_out[TagFirst] && tag_out[TagValid] && !stall;
        res_en     = (state_q == StLatch) && !stall;
        wr_en_c    = (state_q == StWrite) && !stall;
        done       = (state_q == StDone) && !stall;
        row_addr_a = '0;
        col_addr_a = '0;
        row_addr_b = '0;
        col_addr_b = '0;
        row_addr_c = '0;
        col_addr_c = '0;
        if (state_q != StIdle) begin
            row_addr_a = ADDR_W'(i_q);
            col_addr_a = ADDR_W'(k_q);
            row_addr_b = ADDR_W'(k_q);
            col_addr_b = ADDR_W'(j_q);
            row_addr_c = ADDR_W'(i_q);
            col_addr_c = ADDR_W'(j_q);
        end
    end

endmodule

// File: tb/tb_matmul_ctrl_param.sv
// Bench for matmul_ctrl_param: three configurations, each checked every cycle against a
// progress-based schedule model, with a behavioural datapath and golden product for C.
`timescale 1ns/1ps
module tb_matmul_ctrl_param;

    localparam int NCFG   = 3;
    localparam int ADDR_W = 4;
    localparam int unsigned CFG_M [NCFG] = '{10, 2, 1};
    localparam int unsigned CFG_K [NCFG] = '{10, 3, 1};
    localparam int unsigned CFG_P [NCFG] = '{10, 2, 3};
    localparam int unsigned CFG_L [NCFG] = '{1, 2, 3};
    // Hand-computed cycle index (accept edge = 0) of the done pulse and of the first acc_en.
    localparam int unsigned EXP_DONE [NCFG] = '{1301, 29, 19};
    localparam int unsigned EXP_ACC1 [NCFG] = '{2, 3, 4};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input int cfg, input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL cfg%0d %s: got %0d expected %0d at %0t", cfg, nm, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int unsigned M   = CFG_M[g];
        localparam int unsigned K   = CFG_K[g];
        localparam int unsigned P   = CFG_P[g];
        localparam int unsigned L   = CFG_L[g];
        localparam int unsigned E   = K + L + 2;
        localparam int unsigned NEL = M * P;

        logic reset, start, stall;
        logic busy, done, rd_en_a, rd_en_b, acc_en, acc_first, res_en, wr_en_c;
        logic [ADDR_W-1:0] row_addr_a, col_addr_a, row_addr_b, col_addr_b;
        logic [ADDR_W-1:0] row_addr_c, col_addr_c;

        matmul_ctrl_param #(
            .DIM_M  (M),
            .DIM_K  (K),
            .DIM_P  (P),
            .ADDR_W (ADDR_W),
            .RD_LAT (L)
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .start      (start),
            .stall      (stall),
            .busy       (busy),
            .done       (done),
            .rd_en_a    (rd_en_a),
            .row_addr_a (row_addr_a),
            .col_addr_a (col_addr_a),
            .rd_en_b    (rd_en_b),
            .row_addr_b (row_addr_b),
            .col_addr_b (col_addr_b),
            .acc_en     (acc_en),
            .acc_first  (acc_first),
            .res_en     (res_en),
            .wr_en_c    (wr_en_c),
            .row_addr_c (row_addr_c),
            .col_addr_c (col_addr_c)
        );

        // Model state: a run is just a count of non-stalled cycles since the accept edge.
        bit          mdl_ok, mdl_act, fin;
        int unsigned mdl_prog, gen;
        int unsigned a_mem [16][16];
        int unsigned b_mem [16][16];
        int unsigned c_mem [16][16];
        int unsigned c_gen [16][16];
        int unsigned prod_q [L];
        int unsigned acc_q, res_q;

        initial begin
            int unsigned el, ph, ei, ej, ek;
            bit e_busy, e_done, e_rd, e_acc, e_first, e_res, e_wr;
            bit s_rst, s_start, s_stall, d_rd, d_acc, d_first, d_res, d_wr;
            int unsigned d_ra, d_ca, d_rb, d_cb, d_rc, d_cc;
            mdl_ok = 0; mdl_act = 0; mdl_prog = 0; acc_q = 0; res_q = 0;
            for (int s = 0; s < int'(L); s++) prod_q[s] = 0;
            for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) c_gen[r][c] = 0;
            forever begin
                @(negedge clk);
                {e_busy, e_done, e_rd, e_acc, e_first, e_res, e_wr} = '0;
                ei = 0; ej = 0; ek = 0;
                if (mdl_act) begin
                    el = mdl_prog / E;
                    ph = mdl_prog % E;
                    e_busy = 1;
                    if (el == NEL) begin
                        ei = M - 1; ej = P - 1;
                        e_done = !stall;
                    end else begin
                        ei = el / P; ej = el % P;
                        if (ph < K) begin ek = ph; e_rd = !stall; end
                        e_acc   = (ph >= L) && (ph < L + K) && !stall;
                        e_first = e_acc && (ph == L);
                        e_res   = (ph == K + L) && !stall;
                        e_wr    = (ph == K + L + 1) && !stall;
                    end
                end
                if (mdl_ok) begin
                    chk(g, "busy", busy, e_busy);
                    chk(g, "done", done, e_done);
                    chk(g, "rd_en_a", rd_en_a, e_rd);
                    chk(g, "rd_en_b", rd_en_b, e_rd);
                    chk(g, "acc_en", acc_en, e_acc);
                    chk(g, "acc_first", acc_first, e_first);
                    chk(g, "res_en", res_en, e_res);
                    chk(g, "wr_en_c", wr_en_c, e_wr);
                    chk(g, "row_addr_a", row_addr_a, ei);
                    chk(g, "col_addr_a", col_addr_a, ek);
                    chk(g, "row_addr_b", row_addr_b, ek);
                    chk(g, "col_addr_b", col_addr_b, ej);
                    chk(g, "row_addr_c", row_addr_c, ei);
                    chk(g, "col_addr_c", col_addr_c, ej);
                end
                s_rst = reset; s_start = start; s_stall = stall;
                d_rd = rd_en_a && rd_en_b; d_acc = acc_en; d_first = acc_first;
                d_res = res_en; d_wr = wr_en_c;
                d_ra = row_addr_a; d_ca = col_addr_a; d_rb = row_addr_b; d_cb = col_addr_b;
                d_rc = row_addr_c; d_cc = col_addr_c;
                @(posedge clk);
                if (s_rst) begin
                    mdl_ok = 1; mdl_act = 0;
                end else if (!mdl_act) begin
                    if (s_start && !s_stall) begin mdl_act = 1; mdl_prog = 0; end
                end else if (!s_stall) begin
                    if (mdl_prog == NEL * E) mdl_act = 0;
                    else mdl_prog++;
                end
                // Behavioural datapath driven by the DUT's enables; stall freezes it too.
                if (!s_stall) begin
                    if (d_wr) begin c_mem[d_rc][d_cc] = res_q; c_gen[d_rc][d_cc] = gen; end
                    if (d_res) res_q = acc_q;
                    if (d_acc) acc_q = d_first ? prod_q[L-1] : acc_q + prod_q[L-1];
                    for (int s = int'(L) - 1; s > 0; s--) prod_q[s] = prod_q[s-1];
                    prod_q[0] = d_rd ? a_mem[d_ra][d_ca] * b_mem[d_rb][d_cb] : 0;
                end
            end
        end

        task automatic fill_ab();
            for (int r = 0; r < 16; r++) begin
                for (int c = 0; c < 16; c++) begin
                    a_mem[r][c] = $urandom_range(0, 255);
                    b_mem[r][c] = $urandom_range(0, 255);
                end
            end
            gen++;
        endtask

        task automatic check_c(input string nm);
            int unsigned sum;
            for (int r = 0; r < int'(M); r++) begin
                for (int c = 0; c < int'(P); c++) begin
                    sum = 0;
                    for (int k = 0; k < int'(K); k++) sum += a_mem[r][k] * b_mem[k][c];
                    chk(g, {nm, "_c_value"}, c_mem[r][c], sum);
                    chk(g, {nm, "_c_written"}, c_gen[r][c], gen);
                end
            end
        endtask

        task automatic kick();
            start = 1;
            @(posedge clk); #1;
            start = 0;
        endtask

        // Mode 0 plain, 1 random stalls plus 3-cycle stall in DONE, 2 start pulse while busy,
        // 3 start held high. Cycle 1 is the first cycle after the accept edge.
        task automatic run_to_done(input int mode, output int unsigned cyc,
                                   output int unsigned nst, output int unsigned acc1);
            bit got;
            int unsigned dst;
            got = 0; cyc = 0; nst = 0; acc1 = 0; dst = 0;
            while (!got && cyc < 4 * NEL * E + 50) begin
                start = (mode == 3) || (mode == 2 && cyc == 5);
                stall = 0;
                if (mode == 1) begin
                    if (mdl_act && mdl_prog == NEL * E && dst < 3) begin
                        stall = 1; dst++;
                    end else begin
                        stall = ($urandom_range(0, 5) == 0);
                    end
                end
                @(negedge clk);
                cyc++;
                if (stall) nst++;
                if (acc_en && acc1 == 0) acc1 = cyc;
                if (done) got = 1;
                @(posedge clk); #1;
            end
            stall = 0;
            if (mode != 3) start = 0;
            chk(g, "run_reached_done", got, 1);
        endtask

        initial begin
            int unsigned cyc, nst, acc1, target;
            bit hit;
            fin = 0; gen = 0; reset = 1; start = 0; stall = 0;
            fill_ab();
            repeat (3) @(posedge clk);
            #1;
            @(negedge clk);
            chk(g, "reset_busy", busy, 0);
            chk(g, "reset_done", done, 0);
            chk(g, "reset_enables", {rd_en_a, rd_en_b, acc_en, res_en, wr_en_c}, 0);
            chk(g, "reset_addrs", {row_addr_a, col_addr_a, row_addr_b, col_addr_b,
                                   row_addr_c, col_addr_c}, 0);
            @(posedge clk); #1;
            reset = 0;
            @(posedge clk); #1;

            kick();
            run_to_done(0, cyc, nst, acc1);
            chk(g, "plain_done_cycle", cyc, EXP_DONE[g]);
            chk(g, "plain_first_acc_cycle", acc1, EXP_ACC1[g]);
            check_c("plain");

            fill_ab();
            kick();
            run_to_done(1, cyc, nst, acc1);
            chk(g, "stall_done_cycle", cyc, EXP_DONE[g] + nst);
            check_c("stall");

            stall = 1; start = 1;
            repeat (3) begin
                @(negedge clk);
                chk(g, "idle_stall_blocks_start", busy, 0);
                @(posedge clk); #1;
            end
            stall = 0; start = 0;
            @(posedge clk); #1;

            kick();
            run_to_done(2, cyc, nst, acc1);
            chk(g, "busy_start_ignored_cycle", cyc, EXP_DONE[g]);
            @(negedge clk);
            chk(g, "no_rerun_after_pulse", busy, 0);
            @(posedge clk); #1;

            start = 1;
            @(posedge clk); #1;
            run_to_done(3, cyc, nst, acc1);
            chk(g, "handshake1_done_cycle", cyc, EXP_DONE[g]);
            @(negedge clk);
            chk(g, "handshake_idle_gap", busy, 0);
            @(posedge clk); #1;
            run_to_done(3, cyc, nst, acc1);
            start = 0;
            chk(g, "handshake2_done_cycle", cyc, EXP_DONE[g]);
            check_c("handshake");
            @(posedge clk); #1;

            kick();
            target = ((P + 1 < NEL - 1) ? P + 1 : NEL - 1) * E + $urandom_range(0, E - 1);
            hit = 0;
            for (int n = 0; n < int'(4 * NEL * E) && !hit; n++) begin
                if (mdl_act && mdl_prog >= target) hit = 1;
                else begin @(posedge clk); #1; end
            end
            chk(g, "reached_reset_point", hit, 1);
            reset = 1;
            @(posedge clk); #1;
            reset = 0;
            @(negedge clk);
            chk(g, "midrun_reset_busy", busy, 0);
            chk(g, "midrun_reset_done", done, 0);
            chk(g, "midrun_reset_wr", wr_en_c, 0);
            @(posedge clk); #1;
            fill_ab();
            kick();
            run_to_done(0, cyc, nst, acc1);
            chk(g, "rerun_done_cycle", cyc, EXP_DONE[g]);
            check_c("rerun");
            fin = 1;
        end
    end

    initial begin
        bit all_fin;
        all_fin = 0;
        for (int c = 0; c < 60000 && !all_fin; c++) begin
            @(posedge clk);
            all_fin = g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin;
        end
        if (!all_fin) begin
            checks++;
            errors++;
            $display("FAIL watchdog: got unfinished expected all configurations finished");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
